combolock_seq: RTL
==================

Name: combolock_seq

Overview:
- Parametrised successor to the single-digit combination lock.
- Accepts a multi-digit code, one digit per conditioned `enter`/`change` pulse, and compares it against a stored code.
- Supports re-programming the code, a failed-attempt counter, and a timed alarm lockout.
- Sits behind the existing pulse conditioners (one per button) and drives the 7-segment status display.

Parameters:
- DIGIT_W, 4: width of one code digit (the `password` switch group).
- CODE_LEN, 4: number of digits per code (1..15).
- MAX_TRIES, 3: consecutive wrong codes that trigger ALARM (1..15).
- LOCKOUT_CYC, 1000: ALARM duration in clock cycles; 0 means permanent until reset.
- DEFAULT_CODE, 16'h4321: code loaded at reset, width CODE_LEN*DIGIT_W; digit i is at bits [i*DIGIT_W +: DIGIT_W], digit 0 entered first.

Ports:
- Clock  in  1  system clock; all state updates on the rising edge.
- Resetn  in  1  synchronous active-low reset, sampled on the rising edge of Clock.
- password  in  DIGIT_W  digit value, sampled on an enter/change pulse.
- enterpulse  in  1  one-cycle conditioned enter pulse.
- changepulse  in  1  one-cycle conditioned change pulse.
- clear  in  1  level; discards the partial entry.
- leds  out  [0:6]  7-segment status pattern.
- open  out  1  high in OPEN.
- alarm  out  1  high in ALARM.
- digit_cnt  out  4  digits collected in the current entry.
- fails  out  4  consecutive wrong-code count.

Behaviour:
- States: LOCKED, NEW, OPEN, ALARM.
- All outputs are registered; every response appears the cycle after the triggering pulse.
- Reset (Resetn=0 at edge):
  - state=LOCKED, code=DEFAULT_CODE, entry buffer=0, digit_cnt=0, fails=0, lockout counter=0.
  - leds=7'b1111110, open=0, alarm=0.
  - Reset mid-operation discards everything, including a half-programmed code.
- Pulse rule: a "pulse" is enterpulse|changepulse. If both are high in the same cycle, enter wins and change is ignored.
- LOCKED:
  - A pulse with digit_cnt<CODE_LEN-1 stores password at position digit_cnt and increments digit_cnt.
  - A pulse supplying the final digit (digit_cnt==CODE_LEN-1) compares the full buffer, including this digit, against code; digit_cnt then returns to 0.
  - Match via enter -> OPEN, fails=0.
  - Match via change -> NEW, fails=0.
  - Mismatch -> fails+1. If the new value equals MAX_TRIES -> ALARM and the lockout counter loads LOCKOUT_CYC. Otherwise stay in LOCKED.
- NEW:
  - Pulses collect CODE_LEN digits the same way.
  - On the final digit, code is replaced by the full buffer and the state returns to LOCKED.
  - The old code stays active until that final digit is accepted.
- clear (LOCKED or NEW), when no pulse is present:
  - digit_cnt=0.
  - In NEW it aborts programming: old code retained, state -> LOCKED.
  - clear has priority over a same-cycle pulse: the pulse is dropped.
- OPEN:
  - enterpulse -> LOCKED; the digit is ignored.
  - changepulse and clear are ignored.
- ALARM:
  - All pulses and clear are ignored.
  - If LOCKOUT_CYC>0, the counter decrements each cycle; on reaching 0 -> LOCKED, fails=0, digit_cnt=0.
  - If LOCKOUT_CYC==0 -> no exit except reset.
- fails saturates at MAX_TRIES and is cleared only by a successful match, lockout expiry, or reset.
- leds by state:
  - LOCKED: 7'b1111110
  - NEW: 7'b1101010
  - ALARM: 7'b0001000
  - OPEN: 7'b0000001
- Lockout counter width is $clog2(LOCKOUT_CYC+1), minimum 1.

Optional Feature:
- Macro COMBOLOCK_MASTER_EN adds parameter MASTER_CODE (width CODE_LEN*DIGIT_W, default all-ones).
- Defined:
  - In ALARM, pulses collect digits (digit_cnt counts).
  - A full entry equal to MASTER_CODE -> LOCKED with fails=0 the next cycle.
  - A mismatch clears the buffer and restarts the full lockout count.
  - In LOCKED, entering MASTER_CODE via change -> NEW regardless of the stored code.
- Undefined: ALARM ignores all input as specified above; MASTER_CODE does not exist.

Test Plan (DIGIT_W=4, CODE_LEN=4, MAX_TRIES=3, LOCKOUT_CYC=8, DEFAULT_CODE=16'h4321):
- Reset, then enter digits 1,2,3,4 -> open=1, leds=7'b0000001, fails=0; another enterpulse -> LOCKED, leds=7'b1111110.
- Digits 1,2,3 via enter, then 4 via change -> NEW (leds=7'b1101010); enter 9,9,9,9 -> LOCKED; entering 1,2,3,4 leaves fails=1; entering 9,9,9,9 -> OPEN.
- Three wrong entries (5,5,5,5 ×3) -> fails=1,2,3; alarm=1 after the 12th digit; pulses ignored; alarm drops exactly 8 cycles later; fails=0.
- Enter 1,2, assert clear, then enter 1,2,3,4 -> OPEN (digit_cnt back to 0 after clear); in NEW, 2 digits then clear -> LOCKED with old code 4321 still valid.
- Same-cycle enterpulse&changepulse on the final digit of 1,2,3,4 -> OPEN, not NEW; Resetn=0 mid-NEW after 2 digits -> code=4321, LOCKED, all counters 0.
- With COMBOLOCK_MASTER_EN, MASTER_CODE=16'hFFFF: in ALARM, enter F,F,F,F -> LOCKED next cycle, fails=0; without the macro, the same stimulus keeps ALARM for the full 8 cycles.

Source files
------------

// File: rtl/combolock_seq_if.sv
// combolock_seq_if: digit/pulse inputs and status outputs of the multi-digit combination lock
interface combolock_seq_if #(
  parameter int DIGIT_W = 4
);
  logic [DIGIT_W-1:0] password;
  logic               enterpulse;
  logic               changepulse;
  logic               clear;
  logic [0:6]         leds;
  logic               open;
  logic               alarm;
  logic [3:0]         digit_cnt;
  logic [3:0]         fails;
  modport master (
    output password, enterpulse, changepulse, clear,
    input  leds, open, alarm, digit_cnt, fails
  );
  modport slave (
    input  password, enterpulse, changepulse, clear,
    output leds, open, alarm, digit_cnt, fails
  );
endinterface

// File: rtl/combolock_seq.sv
// combolock_seq: multi-digit combination lock with reprogramming, fail counter and timed alarm lockout
// COMBOLOCK_MASTER_EN adds MASTER_CODE: clears ALARM early and forces programming from LOCKED via change.
module combolock_seq #(
  parameter int DIGIT_W = 4,
  parameter int CODE_LEN = 4,
  parameter int MAX_TRIES = 3,
  parameter int LOCKOUT_CYC = 1000,
  parameter logic [CODE_LEN*DIGIT_W-1:0] DEFAULT_CODE = 16'h4321
`ifdef COMBOLOCK_MASTER_EN
  , parameter logic [CODE_LEN*DIGIT_W-1:0] MASTER_CODE = '1
`endif
) (
  input logic          Clock,
  input logic          Resetn,
  combolock_seq_if.slave bus
);
  localparam int CW = CODE_LEN * DIGIT_W;
  localparam int LW = (LOCKOUT_CYC > 0) ? $clog2(LOCKOUT_CYC + 1) : 1;
  typedef enum logic [1:0] {LOCKED, NEW, OPEN, ALARM} state_t;
  state_t          state, state_n;
  logic [CW-1:0]   code, code_n, entry, entry_n, full;
  logic [3:0]      cnt, cnt_n, fails, fails_n;
  logic [LW-1:0]   lock, lock_n;
  logic [0:6]      leds_n;
  logic            open_n, alarm_n;
  logic            pulse, last;
  assign pulse = bus.enterpulse | bus.changepulse;
  assign last  = cnt == 4'(CODE_LEN - 1);
  // full is the buffer as it would look with the current digit written in
  always_comb begin
    full = entry;
    full[int'(cnt)*DIGIT_W +: DIGIT_W] = bus.password;
  end
`ifdef COMBOLOCK_MASTER_EN
  logic mmatch;
  assign mmatch = full == MASTER_CODE;
`endif
  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      state         <= LOCKED;
      code          <= DEFAULT_CODE;
      entry         <= '0;
      cnt           <= '0;
      fails         <= '0;
      lock          <= '0;
      bus.leds      <= 7'b1111110;
      bus.open      <= 1'b0;
      bus.alarm     <= 1'b0;
    end else begin
      state         <= state_n;
      code          <= code_n;
      entry         <= entry_n;
      cnt           <= cnt_n;
      fails         <= fails_n;
      lock          <= lock_n;
      bus.leds      <= leds_n;
      bus.open      <= open_n;
      bus.alarm     <= alarm_n;
    end
  end
  assign bus.digit_cnt = cnt;
  assign bus.fails     = fails;
  always_comb begin
    state_n = state;
    code_n  = code;
    entry_n = entry;
    cnt_n   = cnt;
    fails_n = fails;
    lock_n  = lock;
    case (state)
      LOCKED, NEW: begin
        if (bus.clear) begin
          cnt_n   = '0;
          entry_n = '0;
          state_n = LOCKED;
        end else if (pulse && !last) begin
          entry_n = full;
          cnt_n   = cnt + 4'd1;
        end else if (pulse) begin
          entry_n = '0;
          cnt_n   = '0;
          if (state == NEW) begin
            code_n  = full;
            state_n = LOCKED;
          end else if (full == code) begin
            state_n = bus.enterpulse ? OPEN : NEW;
            fails_n = '0;
          end
`ifdef COMBOLOCK_MASTER_EN
          else if (!bus.enterpulse && mmatch) begin
            state_n = NEW;
            fails_n = '0;
          end
`endif
          else begin
            fails_n = (fails < 4'(MAX_TRIES)) ? fails + 4'd1 : fails;
            if (fails_n == 4'(MAX_TRIES)) begin
              state_n = ALARM;
              lock_n  = LW'(LOCKOUT_CYC);
            end
          end
        end
      end
      OPEN: state_n = bus.enterpulse ? LOCKED : OPEN;
      ALARM: begin
        // a zero lockout never reaches 1, so the alarm holds until reset
        if (lock == LW'(1)) begin
          state_n = LOCKED;
          fails_n = '0;
          cnt_n   = '0;
          entry_n = '0;
          lock_n  = '0;
        end else if (lock != '0) begin
          lock_n = lock - LW'(1);
        end
`ifdef COMBOLOCK_MASTER_EN
        if (pulse && last) begin
          entry_n = '0;
          cnt_n   = '0;
          if (mmatch) begin
            state_n = LOCKED;
            fails_n = '0;
            lock_n  = '0;
          end else begin
            state_n = ALARM;
            fails_n = fails;
            lock_n  = LW'(LOCKOUT_CYC);
          end
        end else if (pulse && state_n == ALARM) begin
          entry_n = full;
          cnt_n   = cnt + 4'd1;
        end
`endif
      end
      default: state_n = LOCKED;
    endcase
  end
  always_comb begin
    leds_n  = (state_n == LOCKED) ? 7'b1111110 :
              (state_n == NEW)    ? 7'b1101010 :
              (state_n == ALARM)  ? 7'b0001000 : 7'b0000001;
    open_n  = state_n == OPEN;
    alarm_n = state_n == ALARM;
  end
endmodule
